// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction-fetch stage and its next-PC mux.
// The branch unit imports the same FonteCP codes, so the encoding lives here once.
// Contents: next-PC source codes, FSM state type, opcode field width.
package busca_instrucao_pkg;

    // Next-PC source select codes
    localparam logic [1:0] FONTE_INC    = 2'b00;  // pc + 1
    localparam logic [1:0] FONTE_ULA    = 2'b01;  // ALU result (branch target)
    localparam logic [1:0] FONTE_JMP    = 2'b10;  // immediate field of ir (jump)
    localparam logic [1:0] FONTE_MANTEM = 2'b11;  // same pc (refetch)

    // Opcode occupies the top OPCODE_W bits of the instruction word
    localparam int OPCODE_W = 4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        BUSCA     = 2'd0,  // raise the memory request
        AGUARDA   = 2'd1,  // request outstanding, wait for ack
        ESPERA_CP = 2'd2   // ir valid, wait for the control unit to write pc
    } estado_t;

endpackage

// File: rtl/busca_instrucao_proximo_pc.sv
// Next-PC selector: pc+1, ALU result, jump immediate or same pc.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when prox is committed.
// Ports:
//   pc, ula_resultado, imediato  in  ADDR_W  candidate sources
//   fonte                        in  2       source select (FONTE_* codes)
//   prox                         out ADDR_W  selected next PC
module proximo_pc
    import busca_instrucao_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ula_resultado,
    input  logic [ADDR_W-1:0] imediato,
    input  logic [1:0]        fonte,
    output logic [ADDR_W-1:0] prox
);

    logic [ADDR_W-1:0] pc_inc;

    // Width-limited add: all-ones wraps to zero
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        prox = pc;
        case (fonte)
            FONTE_INC:    prox = pc_inc;
            FONTE_ULA:    prox = ula_resultado;
            FONTE_JMP:    prox = imediato;
            FONTE_MANTEM: prox = pc;
            default:      prox = pc;
        endcase
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns pc/ir, fetches over req/ack, feeds the control unit.
// Latency: pc write at edge N -> mem_req at N+1 -> ir loaded at N+2 with zero-wait ack.
// Backpressure: mem_req/mem_addr held until mem_ack; ir held until the next pc write.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   EscCP, EscCondCP, zero         pc write strobes (conditional one qualified by zero)
//   FonteCP, ula_resultado         next-PC select and ALU branch target
//   mem_req/mem_addr/mem_rdata/mem_ack  instruction memory handshake
//   pc, ir, opcode, imediato       architectural state and decoded fields
//   ir_valido                      ir holds the instruction at pc
//   erro_seq                       sticky: pc strobe seen outside ESPERA_CP
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EscCP,
    input  logic              EscCondCP,
    input  logic              zero,
    input  logic [1:0]        FonteCP,
    input  logic [ADDR_W-1:0] ula_resultado,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] imediato,
    output logic              ir_valido,
    output logic              erro_seq
);

    estado_t           estado;
    estado_t           estado_nxt;
    logic              wr;
    logic              carrega_ir;
    logic              carrega_pc;
    logic              pede_mem;
    logic [ADDR_W-1:0] prox;

    assign wr       = EscCP | (EscCondCP & zero);
    assign opcode   = ir[DATA_W-1 -: OPCODE_W];
    assign imediato = ir[ADDR_W-1:0];
    assign mem_addr = pc;

    proximo_pc #(
        .ADDR_W(ADDR_W)
    ) u_proximo_pc (
        .pc            (pc),
        .ula_resultado (ula_resultado),
        .imediato      (imediato),
        .fonte         (FonteCP),
        .prox          (prox)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= BUSCA;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next state and register-load strobes
    always_comb begin
        estado_nxt = estado;
        carrega_ir = 1'b0;
        carrega_pc = 1'b0;
        pede_mem   = 1'b0;
        case (estado)
            BUSCA: begin
                pede_mem   = 1'b1;
                estado_nxt = AGUARDA;
            end
            AGUARDA: begin
                if (mem_ack) begin
                    carrega_ir = 1'b1;
                    estado_nxt = ESPERA_CP;
                end
            end
            ESPERA_CP: begin
                if (wr) begin
                    carrega_pc = 1'b1;
                    estado_nxt = BUSCA;
                end
            end
            default: estado_nxt = BUSCA;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            ir_valido <= 1'b0;
            mem_req   <= 1'b0;
            erro_seq  <= 1'b0;
        end else begin
            if (carrega_pc) begin
                pc <= prox;
            end

            if (carrega_ir) begin
                ir <= mem_rdata;
            end

            // ir itself is left untouched on a pc write; only the valid flag drops
            if (carrega_ir) begin
                ir_valido <= 1'b1;
            end else if (carrega_pc) begin
                ir_valido <= 1'b0;
            end

            if (pede_mem) begin
                mem_req <= 1'b1;
            end else if (carrega_ir) begin
                mem_req <= 1'b0;
            end

            // A strobe while a fetch is in flight means the control unit is out of step
            if (wr && (estado != ESPERA_CP)) begin
                erro_seq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a small instruction memory model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_ack driven directly by the stimulus to model wait states.
module tb_busca_instrucao;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              EscCP;
    logic              EscCondCP;
    logic              zero;
    logic [1:0]        FonteCP;
    logic [ADDR_W-1:0] ula_resultado;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] imediato;
    logic              ir_valido;
    logic              erro_seq;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    busca_instrucao #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (12'h000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .EscCP         (EscCP),
        .EscCondCP     (EscCondCP),
        .zero          (zero),
        .FonteCP       (FonteCP),
        .ula_resultado (ula_resultado),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .pc            (pc),
        .ir            (ir),
        .opcode        (opcode),
        .imediato      (imediato),
        .ir_valido     (ir_valido),
        .erro_seq      (erro_seq)
    );

    assign mem_rdata = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the strobes for exactly one edge, then release them
    task automatic do_wr(input logic esc, input logic cond, input logic z,
                         input logic [1:0] fonte, input logic [ADDR_W-1:0] ula);
        EscCP         = esc;
        EscCondCP     = cond;
        zero          = z;
        FonteCP       = fonte;
        ula_resultado = ula;
        step();
        EscCP         = 1'b0;
        EscCondCP     = 1'b0;
        zero          = 1'b0;
        FonteCP       = 2'b00;
        ula_resultado = '0;
    endtask

    // BUSCA -> AGUARDA -> ESPERA_CP with ack already high
    task automatic fetch();
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = 16'hDEAD;
        end
        mem[12'h000] = 16'h1005;
        mem[12'h001] = 16'h7002;
        mem[12'h003] = 16'h5FFF;
        mem[12'h005] = 16'h20A0;
        mem[12'h006] = 16'h30A0;
        mem[12'h0A0] = 16'h4123;
        mem[12'hFFF] = 16'h6001;

        rst_n         = 1'b0;
        EscCP         = 1'b0;
        EscCondCP     = 1'b0;
        zero          = 1'b0;
        FonteCP       = 2'b00;
        ula_resultado = '0;
        mem_ack       = 1'b1;

        // Reset state, one edge already seen while held in reset
        #12;
        check("rst_mem_req",   32'(mem_req),   32'h0);
        check("rst_pc",        32'(pc),        32'h000);
        check("rst_ir",        32'(ir),        32'h0000);
        check("rst_ir_valido", 32'(ir_valido), 32'h0);
        check("rst_erro_seq",  32'(erro_seq),  32'h0);
        rst_n = 1'b1;

        // First fetch after reset release with zero-wait ack
        step();
        check("t1_req_edge1",   32'(mem_req),   32'h1);
        check("t1_addr_edge1",  32'(mem_addr),  32'h000);
        check("t1_ivld_edge1",  32'(ir_valido), 32'h0);
        step();
        check("t1_ir",          32'(ir),        32'h1005);
        check("t1_ir_valido",   32'(ir_valido), 32'h1);
        check("t1_req_drop",    32'(mem_req),   32'h0);
        check("t1_opcode",      32'(opcode),    32'h1);
        check("t1_imediato",    32'(imediato),  32'h005);

        // Jump to 5 using the immediate of mem[0]
        do_wr(1'b1, 1'b0, 1'b0, 2'b10, '0);
        check("jmp5_pc",        32'(pc),        32'h005);
        check("jmp5_ivld",      32'(ir_valido), 32'h0);
        check("jmp5_ir_kept",   32'(ir),        32'h1005);
        fetch();
        check("jmp5_ir",        32'(ir),        32'h20A0);

        // Increment 5 -> 6
        do_wr(1'b1, 1'b0, 1'b0, 2'b00, '0);
        check("inc_pc",         32'(pc),        32'h006);
        step();
        check("inc_req",        32'(mem_req),   32'h1);
        check("inc_addr",       32'(mem_addr),  32'h006);
        step();
        check("inc_ir",         32'(ir),        32'h30A0);

        // Jump to 0A0
        do_wr(1'b1, 1'b0, 1'b0, 2'b10, '0);
        check("jmpA0_pc",       32'(pc),        32'h0A0);
        fetch();
        check("jmpA0_ir",       32'(ir),        32'h4123);

        // Conditional branch not taken: nothing moves, no error
        do_wr(1'b0, 1'b1, 1'b0, 2'b01, 12'h003);
        check("bnt_pc",         32'(pc),        32'h0A0);
        check("bnt_ivld",       32'(ir_valido), 32'h1);
        check("bnt_erro",       32'(erro_seq),  32'h0);
        step();
        check("bnt_no_req",     32'(mem_req),   32'h0);

        // Conditional branch taken to the ALU result
        do_wr(1'b0, 1'b1, 1'b1, 2'b01, 12'h003);
        check("bt_pc",          32'(pc),        32'h003);
        fetch();
        check("bt_ir",          32'(ir),        32'h5FFF);

        // Refetch the same address, both strobes together
        do_wr(1'b1, 1'b1, 1'b1, 2'b11, 12'h777);
        check("ref_pc",         32'(pc),        32'h003);
        check("ref_ivld",       32'(ir_valido), 32'h0);
        fetch();
        check("ref_ir",         32'(ir),        32'h5FFF);
        check("ref_ivld2",      32'(ir_valido), 32'h1);

        // Jump to FFF then increment wraps to 0
        do_wr(1'b1, 1'b0, 1'b0, 2'b10, '0);
        check("jmpFFF_pc",      32'(pc),        32'hFFF);
        fetch();
        check("jmpFFF_ir",      32'(ir),        32'h6001);
        do_wr(1'b1, 1'b0, 1'b0, 2'b00, '0);
        check("wrap_pc",        32'(pc),        32'h000);
        fetch();
        check("wrap_ir",        32'(ir),        32'h1005);

        // Wait states on ack, with a stray strobe mid-wait
        mem_ack = 1'b0;
        do_wr(1'b1, 1'b0, 1'b0, 2'b00, '0);
        check("ws_pc",          32'(pc),        32'h001);
        step();
        check("ws_req0",        32'(mem_req),   32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                EscCP   = 1'b1;
                FonteCP = 2'b00;
            end
            step();
            EscCP = 1'b0;
            check($sformatf("ws_req%0d", i + 1),  32'(mem_req),  32'h1);
            check($sformatf("ws_addr%0d", i + 1), 32'(mem_addr), 32'h001);
            check($sformatf("ws_pc%0d", i + 1),   32'(pc),       32'h001);
        end
        check("ws_erro",        32'(erro_seq),  32'h1);
        check("ws_ivld",        32'(ir_valido), 32'h0);
        check("ws_ir_kept",     32'(ir),        32'h1005);
        mem_ack = 1'b1;
        step();
        check("ws_ir",          32'(ir),        32'h7002);
        check("ws_ivld_done",   32'(ir_valido), 32'h1);
        check("ws_req_done",    32'(mem_req),   32'h0);
        check("ws_erro_sticky", 32'(erro_seq),  32'h1);

        // Asynchronous reset in the middle of an outstanding fetch
        mem_ack = 1'b0;
        do_wr(1'b1, 1'b0, 1'b0, 2'b00, '0);
        check("ar_pc_pre",      32'(pc),        32'h002);
        step();
        check("ar_req_pre",     32'(mem_req),   32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",         32'(mem_req),   32'h0);
        check("ar_pc",          32'(pc),        32'h000);
        check("ar_ir",          32'(ir),        32'h0000);
        check("ar_ivld",        32'(ir_valido), 32'h0);
        check("ar_erro",        32'(erro_seq),  32'h0);

        // Restart from RESET_PC after release
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rs_req",         32'(mem_req),   32'h1);
        check("rs_addr",        32'(mem_addr),  32'h000);
        step();
        check("rs_ir",          32'(ir),        32'h1005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
